// File: rtl/boot_seq.sv
// Boot/run sequencer: streams an instruction image into IMem, holds and
// releases core reset, then supervises the run. Halt input: BOOT_SEQ_HALT_EN.
module boot_seq #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int RST_HOLD   = 2,
    parameter int RUN_LIMIT  = 1000,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  in_Clk,
    input  logic                  Rst_N,
    input  logic                  in_ld_valid,
    input  logic [INST_WIDTH-1:0] in_ld_data,
    input  logic                  in_ld_last,
    output logic                  out_ld_ready,
    output logic                  out_im_wr_en,
    output logic [ADDR_WIDTH-1:0] out_im_wr_addr,
    output logic [INST_WIDTH-1:0] out_im_wr_data,
    output logic                  out_done_load_inst,
    output logic                  out_core_rst_n,
    input  logic                  in_halt,
    output logic [CNT_WIDTH-1:0]  out_run_cnt,
    output logic                  out_finished,
    output logic                  out_timeout,
    output logic                  out_ld_trunc
);

    localparam int BYTES = INST_WIDTH / 8;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [1:0] {LOAD, HOLD, RUN, DONE} state_t;

    state_t                state, state_n;
    logic [IW-1:0]         idx, idx_n;
    logic [HW-1:0]         hold_cnt, hold_n;
    logic                  ready_n, wr_en_n, done_n, core_n;
    logic                  fin_n, tmo_n, trunc_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [INST_WIDTH-1:0] data_n;
    logic [CNT_WIDTH-1:0]  cnt_n, cnt_inc;
    logic                  accept;
    logic                  halt;

`ifdef BOOT_SEQ_HALT_EN
    assign halt = in_halt;
`else
    logic unused_halt;
    assign unused_halt = in_halt;
    assign halt        = 1'b0;
`endif

    assign accept = in_ld_valid & out_ld_ready;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        hold_n  = hold_cnt;
        ready_n = out_ld_ready;
        wr_en_n = 1'b0;
        addr_n  = out_im_wr_addr;
        data_n  = out_im_wr_data;
        done_n  = out_done_load_inst;
        core_n  = out_core_rst_n;
        cnt_n   = out_run_cnt;
        fin_n   = out_finished;
        tmo_n   = out_timeout;
        trunc_n = out_ld_trunc;
        cnt_inc = (&out_run_cnt) ? out_run_cnt
                                 : out_run_cnt + 1'b1;
        unique case (state)
            LOAD: begin
                ready_n = 1'b1;
                if (accept) begin
                    wr_en_n = 1'b1;
                    addr_n  = ADDR_WIDTH'(idx) * ADDR_WIDTH'(BYTES);
                    data_n  = in_ld_data;
                    idx_n   = idx + 1'b1;
                    // last word or capacity reached closes the image
                    if (in_ld_last || idx == IW'(DEPTH - 1)) begin
                        ready_n = 1'b0;
                        trunc_n = ~in_ld_last;
                        hold_n  = '0;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                done_n = 1'b1;
                if (hold_cnt == HW'(RST_HOLD - 1)) begin
                    core_n  = 1'b1;
                    state_n = RUN;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            RUN: begin
                cnt_n = cnt_inc;
                if (halt) begin
                    fin_n   = 1'b1;
                    state_n = DONE;
                end else if (RUN_LIMIT != 0 &&
                             cnt_inc == CNT_WIDTH'(RUN_LIMIT)) begin
                    tmo_n   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = LOAD;
            end
        endcase
    end

    always_ff @(posedge in_Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state              <= LOAD;
            idx                <= '0;
            hold_cnt           <= '0;
            out_ld_ready       <= 1'b0;
            out_im_wr_en       <= 1'b0;
            out_im_wr_addr     <= '0;
            out_im_wr_data     <= '0;
            out_done_load_inst <= 1'b0;
            out_core_rst_n     <= 1'b0;
            out_run_cnt        <= '0;
            out_finished       <= 1'b0;
            out_timeout        <= 1'b0;
            out_ld_trunc       <= 1'b0;
        end else begin
            state              <= state_n;
            idx                <= idx_n;
            hold_cnt           <= hold_n;
            out_ld_ready       <= ready_n;
            out_im_wr_en       <= wr_en_n;
            out_im_wr_addr     <= addr_n;
            out_im_wr_data     <= data_n;
            out_done_load_inst <= done_n;
            out_core_rst_n     <= core_n;
            out_run_cnt        <= cnt_n;
            out_finished       <= fin_n;
            out_timeout        <= tmo_n;
            out_ld_trunc       <= trunc_n;
        end
    end

endmodule

// File: doc/boot_seq.md
Name: boot_seq

Overview:
- Parametrised boot/run sequencer for the RV64IF core.
- Streams an instruction image into instruction memory through a valid/ready port and raises done_load_inst when the image is complete.
- Then holds the core in reset for a programmable number of cycles, releases it, and supervises execution until a halt or a cycle limit.
- Sits between the image source (bench or host link) and IMem / RV64IF_top reset.

Parameters:
ADDR_WIDTH, 64, width of the IMem write address (byte address)
INST_WIDTH, 32, instruction word width; must be a multiple of 8
DEPTH, 1024, maximum instruction words loaded
RST_HOLD, 2, cycles the core reset stays asserted after the load completes (min 1)
RUN_LIMIT, 1000, run cycles before timeout; 0 = unlimited
CNT_WIDTH, 32, width of the run-cycle counter

Ports:
in_Clk  input  1  clock, rising edge
Rst_N  input  1  asynchronous active-low reset
in_ld_valid  input  1  load word valid
in_ld_data  input  INST_WIDTH  load word
in_ld_last  input  1  marks the final word of the image
out_ld_ready  output  1  sequencer accepts a load word
out_im_wr_en  output  1  IMem write strobe
out_im_wr_addr  output  ADDR_WIDTH  IMem byte address
out_im_wr_data  output  INST_WIDTH  IMem write data
out_done_load_inst  output  1  image fully written (sticky)
out_core_rst_n  output  1  active-low reset to the core
in_halt  input  1  core halt indication
out_run_cnt  output  CNT_WIDTH  cycles spent in RUN
out_finished  output  1  run ended by halt
out_timeout  output  1  run ended by RUN_LIMIT
out_ld_trunc  output  1  image cut off at DEPTH without in_ld_last

Behaviour:
- All outputs are registered.
- Reset (Rst_N=0, asynchronous, any state): state=LOAD, word index=0, out_ld_ready=0, out_im_wr_en=0, out_im_wr_addr=0, out_im_wr_data=0, out_done_load_inst=0, out_core_rst_n=0, out_run_cnt=0, out_finished=0, out_timeout=0, out_ld_trunc=0.
- First edge after Rst_N deasserts: out_ld_ready=1.
- Reset mid-operation: aborts at once; the full image must be reloaded.
- States: LOAD -> HOLD -> RUN -> DONE.
- LOAD:
  - A word is accepted on an edge where in_ld_valid=1 and out_ld_ready=1.
  - On accepting edge k, out_im_wr_en=1 for exactly one cycle after edge k, with out_im_wr_addr = idx*(INST_WIDTH/8) and out_im_wr_data = in_ld_data. idx then increments.
  - Gaps in in_ld_valid are allowed: no write, no index change.
  - Load ends on the accepting edge of a word with in_ld_last=1, or of word idx=DEPTH-1. The DEPTH-1 case without last sets out_ld_trunc=1.
  - On that edge: out_ld_ready=0, state=HOLD.
  - Address never wraps.
- HOLD:
  - out_done_load_inst=1 from the edge after the final write strobe (edge k+1); it stays 1 until reset.
  - out_core_rst_n stays 0 for RST_HOLD cycles counted from HOLD entry, then goes 1 at the edge entering RUN.
- RUN:
  - out_core_rst_n=1; out_run_cnt increments by 1 each edge, saturating at all-ones.
  - in_halt=1 sampled at edge: out_finished=1, state=DONE.
  - Otherwise, if RUN_LIMIT≠0 and the counter is about to reach RUN_LIMIT: out_timeout=1, state=DONE.
  - Halt and limit on the same edge: halt wins (finished=1, timeout=0).
- DONE:
  - Terminal until reset; out_run_cnt frozen.
  - out_core_rst_n remains 1, so the core state stays inspectable.
  - in_ld_valid is ignored in every state except LOAD.

Optional Feature:
- BOOT_SEQ_HALT_EN defined: in_halt is honoured as described.
- Not defined: in_halt is ignored, out_finished is tied 0, and RUN ends only via RUN_LIMIT. With RUN_LIMIT=0 it never ends.

Test Plan:
- Load 4 words 0x00500093, 0x00300113, 0x002081B3, 0x00000073, last on the 4th, valid every cycle:
  - write strobes at addr 0, 4, 8, 12 with matching data;
  - done_load_inst=1 one cycle after the 4th strobe;
  - core_rst_n=1 after RST_HOLD=2 cycles.
- Back-pressure/gaps: valid pattern 1,0,0,1,1 with 3 words -> exactly 3 strobes at 0, 4, 8; no strobe in gap cycles.
- RUN_LIMIT=10, in_halt=0 -> timeout=1, finished=0, run_cnt=10, core_rst_n still 1.
- Macro defined, halt at run cycle 5 that coincides with the limit (RUN_LIMIT=5) -> finished=1, timeout=0, run_cnt=5. Macro undefined, same stimulus -> timeout=1.
- DEPTH=4, send 6 words without last -> 4 strobes (0..12), ld_trunc=1, ld_ready=0 from 4th accept; words 5 and 6 not written.
- Assert Rst_N mid-RUN (run_cnt=7) -> all outputs immediately reset values. Reload 1 word with last -> write at addr 0, normal sequence resumes.
